// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter; result and DONE appear BIN_W+1 cycles after START, START ignored while BUSY.
// Define BCD_LEADING_BLANK_EN to replace leading zero digits with 4'hF (unlit on the display driver).
module bin_to_bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [BIN_W-1:0] BIN,
   output logic [15:0]      BCD,
   output logic             BUSY,
   output logic             DONE,
   output logic             OVF
);

   localparam int WORK_W = 16 + BIN_W;
   localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(9999);
   localparam logic [4:0] LAST_CNT = 5'(BIN_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state, state_nxt;
   logic [4:0]          cnt;
   logic [WORK_W-1:0]   work;
   logic [WORK_W-1:0]   work_nxt;
   logic [15:0]         adj;
   logic                sat;
   logic                last;
   logic                over;
   logic [BIN_W-1:0]    bin_sat;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

`ifdef BCD_LEADING_BLANK_EN
   function automatic logic [15:0] fmt(input logic [15:0] d);
      logic [15:0] r;
      r = d;
      if (d[15:12] == 4'd0) begin
         r[15:12] = 4'hF;
         if (d[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (d[7:4] == 4'd0) r[7:4] = 4'hF;
         end
      end
      return r;
   endfunction
`else
   function automatic logic [15:0] fmt(input logic [15:0] d);
      return d;
   endfunction
`endif

   assign over    = (BIN > MAX_BIN);
   assign bin_sat = over ? MAX_BIN : BIN;
   assign last    = (cnt == LAST_CNT);

   // Values above 9999 are clamped, so the BCD part never needs more than four digits.
   assign adj = {add3(work[BIN_W+12 +: 4]), add3(work[BIN_W+8 +: 4]),
                 add3(work[BIN_W+4 +: 4]),  add3(work[BIN_W +: 4])};
   assign work_nxt = {adj, work[BIN_W-1:0]} << 1;

   assign BUSY = (state == SHIFT);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (START) state_nxt = SHIFT;
         SHIFT: if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         work  <= '0;
         sat   <= 1'b0;
         BCD   <= 16'h0000;
         DONE  <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         state <= state_nxt;
         DONE  <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  work <= {16'h0000, bin_sat};
                  sat  <= over;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               work <= work_nxt;
               cnt  <= cnt + 5'd1;
               if (last) begin
                  BCD  <= fmt(work_nxt[WORK_W-1:BIN_W]);
                  OVF  <= sat;
                  DONE <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: conversions, saturation, ignored START, mid-conversion reset, streaming.
module tb_bin_to_bcd_seq;

   localparam int BIN_W = 14;
`ifdef BCD_LEADING_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST;
   logic             START;
   logic [BIN_W-1:0] BIN;
   logic [15:0]      BCD;
   logic             BUSY;
   logic             DONE;
   logic             OVF;

   int vectors = 0;
   int miscompares = 0;

   bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BIN(BIN),
      .BCD(BCD), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Starts one conversion; optional extra START pulses at given BUSY cycles, optional reset at a BUSY cycle.
   task automatic convert(input string tag, input logic [BIN_W-1:0] bin, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input int pulse_a, input int pulse_b, input int rst_at);
      int lat, busy_n, extra;
      BIN = bin;
      START = 1'b1;
      step();
      START = 1'b0;
      lat = 0;
      busy_n = 0;
      while (!DONE && lat < 40) begin
         if (BUSY) busy_n++;
         if (rst_at > 0 && busy_n == rst_at) break;
         START = (busy_n == pulse_a || busy_n == pulse_b);
         if (START) BIN = 14'd5555;
         step();
         lat++;
      end
      START = 1'b0;
      if (rst_at > 0) begin
         RST = 1'b1;
         step();
         RST = 1'b0;
         chk({tag, "_rst_busy"}, BUSY, 0);
         chk({tag, "_rst_bcd"}, BCD, 16'h0000);
         chk({tag, "_rst_ovf"}, OVF, 0);
         extra = 0;
         repeat (20) begin
            if (DONE || BUSY) extra++;
            step();
         end
         chk({tag, "_rst_no_done"}, extra, 0);
         return;
      end
      chk({tag, "_latency"}, lat, BIN_W);
      chk({tag, "_busy_cycles"}, busy_n, BIN_W);
      chk({tag, "_done"}, DONE, 1);
      chk({tag, "_bcd"}, BCD, exp_bcd);
      chk({tag, "_ovf"}, OVF, exp_ovf);
      step();
      chk({tag, "_done_pulse"}, DONE, 0);
      chk({tag, "_idle"}, BUSY, 0);
      chk({tag, "_bcd_hold"}, BCD, exp_bcd);
   endtask

   initial begin
      int n;
      RST = 1'b1;
      START = 1'b0;
      BIN = '0;
      step();
      step();
      RST = 1'b0;
      chk("reset_bcd", BCD, 16'h0000);
      chk("reset_busy", BUSY, 0);
      chk("reset_done", DONE, 0);
      chk("reset_ovf", OVF, 0);

      convert("zero",  14'd0,     BLANK ? 16'hFFF0 : 16'h0000, 1'b0, -1, -1, 0);
      convert("d1234", 14'd1234,  16'h1234,                    1'b0, -1, -1, 0);
      convert("d9999", 14'd9999,  16'h9999,                    1'b0, -1, -1, 0);
      convert("d10000", 14'd10000, 16'h9999,                   1'b1, -1, -1, 0);
      convert("d16383", 14'd16383, 16'h9999,                   1'b1, -1, -1, 0);
      convert("d7",    14'd7,     BLANK ? 16'hFFF7 : 16'h0007, 1'b0, -1, -1, 0);
      convert("d1005", 14'd1005,  16'h1005,                    1'b0, -1, -1, 0);
      convert("d900",  14'd900,   BLANK ? 16'hF900 : 16'h0900, 1'b0, -1, -1, 0);
      convert("ignore", 14'd321,  BLANK ? 16'hF321 : 16'h0321, 1'b0, 3, 10, 0);
      convert("pre_ovf", 14'd12000, 16'h9999,                  1'b1, -1, -1, 0);
      convert("midrst", 14'd4321, 16'h0000,                    1'b0, -1, -1, 7);
      convert("d88",   14'd88,    BLANK ? 16'hFF88 : 16'h0088, 1'b0, -1, -1, 0);

      // START held high: conversions repeat every BIN_W+1 cycles.
      BIN = 14'd42;
      START = 1'b1;
      n = 0;
      step();
      while (!DONE && n < 40) begin
         step();
         n++;
      end
      chk("held_first_done", DONE, 1);
      chk("held_bcd", BCD, BLANK ? 16'hFF42 : 16'h0042);
      repeat (2) begin
         n = 0;
         step();
         n++;
         while (!DONE && n < 40) begin
            step();
            n++;
         end
         chk("held_period", n, BIN_W + 1);
      end
      START = 1'b0;
      repeat (20) step();
      chk("held_stop_idle", BUSY, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
